// File: rtl/dp_reservation_station_if.sv
// Issue, CDB and ALU-dispatch signals of the DP reservation station.
// The master side issues instructions, drives the CDB and accepts dispatches.
interface dp_reservation_station_if #(
    parameter int unsigned Depth = 4,
    parameter int unsigned OpW   = 4
);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic            issue;
    logic            full;
    logic [OpW-1:0]  issue_op;
    logic [2:0]      issue_dest;
    logic            issue_rdy_a;
    logic            issue_rdy_b;
    logic [31:0]     issue_val_a;
    logic [31:0]     issue_val_b;
    logic [2:0]      issue_tag_a;
    logic [2:0]      issue_tag_b;
    logic [147:0]    cdb;
    logic            ex_valid;
    logic            ex_ready;
    logic [OpW-1:0]  ex_op;
    logic [31:0]     ex_a;
    logic [31:0]     ex_b;
    logic [2:0]      ex_dest;
    logic [CntW-1:0] count;

    modport master (
        output issue, issue_op, issue_dest, issue_rdy_a, issue_rdy_b,
        output issue_val_a, issue_val_b, issue_tag_a, issue_tag_b, cdb, ex_ready,
        input  full, ex_valid, ex_op, ex_a, ex_b, ex_dest, count
    );

    modport slave (
        input  issue, issue_op, issue_dest, issue_rdy_a, issue_rdy_b,
        input  issue_val_a, issue_val_b, issue_tag_a, issue_tag_b, cdb, ex_ready,
        output full, ex_valid, ex_op, ex_a, ex_b, ex_dest, count
    );
endinterface

// File: rtl/dp_reservation_station.sv
// Reservation station for the DP ALU: holds issued instructions until both
// operands are present (snooping the 4-slot CDB by ROB tag) and dispatches
// the lowest-index ready entry over a valid/ready handshake.
module dp_reservation_station #(
    parameter int unsigned Depth = 4,
    parameter int unsigned OpW   = 4
) (
    input logic                    clk_i,
    input logic                    rst_i,
    dp_reservation_station_if.slave rs_if
);
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Depth-1:0] busy_q, busy_d;
    logic [Depth-1:0] rdy_a_q, rdy_a_d;
    logic [Depth-1:0] rdy_b_q, rdy_b_d;
    logic [OpW-1:0]   op_q    [Depth];
    logic [OpW-1:0]   op_d    [Depth];
    logic [2:0]       dest_q  [Depth];
    logic [2:0]       dest_d  [Depth];
    logic [2:0]       tag_a_q [Depth];
    logic [2:0]       tag_a_d [Depth];
    logic [2:0]       tag_b_q [Depth];
    logic [2:0]       tag_b_d [Depth];
    logic [31:0]      val_a_q [Depth];
    logic [31:0]      val_a_d [Depth];
    logic [31:0]      val_b_q [Depth];
    logic [31:0]      val_b_d [Depth];

    logic [31:0]      cdb_val [4];
    logic [2:0]       cdb_tag [4];
    logic [3:0]       cdb_vld;
    logic             unused_cdb;

    logic [Depth-1:0] hit_a, hit_b;
    logic [31:0]      cap_a [Depth];
    logic [31:0]      cap_b [Depth];
    logic             hit_ia, hit_ib;
    logic [31:0]      cap_ia, cap_ib;

    logic             free_found, disp_found;
    logic [IdxW-1:0]  free_idx, disp_idx;
    logic [CntW-1:0]  count;
    logic             full;
    logic             issue_fire, disp_fire;

    // Split the CDB into its four slots; the top nibble carries nothing.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            cdb_val[k] = rs_if.cdb[36*k+4 +: 32];
            cdb_vld[k] = rs_if.cdb[36*k+3];
            cdb_tag[k] = rs_if.cdb[36*k +: 3];
        end
        unused_cdb = ^rs_if.cdb[147:144];
    end

    // Tag match against all CDB slots; scanning downward lets the lowest slot win.
    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            hit_a[i] = 1'b0;
            hit_b[i] = 1'b0;
            cap_a[i] = '0;
            cap_b[i] = '0;
            for (int k = 3; k >= 0; k--) begin
                if (cdb_vld[k] && (cdb_tag[k] == tag_a_q[i])) begin
                    hit_a[i] = 1'b1;
                    cap_a[i] = cdb_val[k];
                end
                if (cdb_vld[k] && (cdb_tag[k] == tag_b_q[i])) begin
                    hit_b[i] = 1'b1;
                    cap_b[i] = cdb_val[k];
                end
            end
        end
        hit_ia = 1'b0;
        hit_ib = 1'b0;
        cap_ia = '0;
        cap_ib = '0;
        for (int k = 3; k >= 0; k--) begin
            if (cdb_vld[k] && (cdb_tag[k] == rs_if.issue_tag_a)) begin
                hit_ia = 1'b1;
                cap_ia = cdb_val[k];
            end
            if (cdb_vld[k] && (cdb_tag[k] == rs_if.issue_tag_b)) begin
                hit_ib = 1'b1;
                cap_ib = cdb_val[k];
            end
        end
    end

    // Lowest free entry for issue, lowest ready entry for dispatch, occupancy.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        disp_found = 1'b0;
        disp_idx   = '0;
        count      = '0;
        for (int i = Depth - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = IdxW'(i);
            end
            if (busy_q[i] && rdy_a_q[i] && rdy_b_q[i]) begin
                disp_found = 1'b1;
                disp_idx   = IdxW'(i);
            end
        end
        for (int i = 0; i < Depth; i++) begin
            count = count + CntW'(busy_q[i]);
        end
        full       = (count == CntW'(Depth));
        issue_fire = rs_if.issue && !full && free_found;
        disp_fire  = disp_found && rs_if.ex_ready;
    end

    // Entry next state: CDB capture, dispatch release, issue write.
    always_comb begin
        busy_d  = busy_q;
        rdy_a_d = rdy_a_q;
        rdy_b_d = rdy_b_q;
        op_d    = op_q;
        dest_d  = dest_q;
        tag_a_d = tag_a_q;
        tag_b_d = tag_b_q;
        val_a_d = val_a_q;
        val_b_d = val_b_q;
        for (int i = 0; i < Depth; i++) begin
            if (busy_q[i] && !rdy_a_q[i] && hit_a[i]) begin
                rdy_a_d[i] = 1'b1;
                val_a_d[i] = cap_a[i];
            end
            if (busy_q[i] && !rdy_b_q[i] && hit_b[i]) begin
                rdy_b_d[i] = 1'b1;
                val_b_d[i] = cap_b[i];
            end
        end
        if (disp_fire) begin
            busy_d[disp_idx] = 1'b0;
        end
        // The issue slot comes from registered Busy, so it never aliases the
        // entry being dispatched this cycle.
        if (issue_fire) begin
            busy_d[free_idx]  = 1'b1;
            op_d[free_idx]    = rs_if.issue_op;
            dest_d[free_idx]  = rs_if.issue_dest;
            tag_a_d[free_idx] = rs_if.issue_tag_a;
            tag_b_d[free_idx] = rs_if.issue_tag_b;
            rdy_a_d[free_idx] = rs_if.issue_rdy_a || hit_ia;
            rdy_b_d[free_idx] = rs_if.issue_rdy_b || hit_ib;
            val_a_d[free_idx] = rs_if.issue_rdy_a ? rs_if.issue_val_a : cap_ia;
            val_b_d[free_idx] = rs_if.issue_rdy_b ? rs_if.issue_val_b : cap_ib;
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q  <= '0;
            rdy_a_q <= '0;
            rdy_b_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                op_q[i]    <= '0;
                dest_q[i]  <= '0;
                tag_a_q[i] <= '0;
                tag_b_q[i] <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            rdy_a_q <= rdy_a_d;
            rdy_b_q <= rdy_b_d;
            op_q    <= op_d;
            dest_q  <= dest_d;
            tag_a_q <= tag_a_d;
            tag_b_q <= tag_b_d;
        end
    end

    // Operand values are only observed behind Busy/Rdy, so they skip reset.
    always_ff @(posedge clk_i) begin
        val_a_q <= val_a_d;
        val_b_q <= val_b_d;
    end

    // Dispatch outputs from registered state only; zeroed when nothing is ready.
    always_comb begin
        rs_if.ex_valid = disp_found;
        rs_if.ex_op    = disp_found ? op_q[disp_idx]    : '0;
        rs_if.ex_a     = disp_found ? val_a_q[disp_idx] : '0;
        rs_if.ex_b     = disp_found ? val_b_q[disp_idx] : '0;
        rs_if.ex_dest  = disp_found ? dest_q[disp_idx]  : '0;
        rs_if.count    = count;
        rs_if.full     = full;
    end
endmodule

// File: doc/dp_reservation_station.md
# dp_reservation_station

Reservation station for the data-processing (DP) execution unit. It holds up to DEPTH issued DP instructions until both source operands are available, capturing missing operands by snooping the CDB by ROB tag. It hands ready instructions to the DP ALU with a valid/ready handshake. The ALU then broadcasts its result on the CDB DP slot, which the reorder buffer consumes.

## Interface
- DEPTH, 4: number of entries; 2..8.
- OPW, 4: ALU opcode width.

- CLK  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Issue  in  1  request to insert an instruction; ignored while Full=1
- Full  out  1  all entries busy
- IssueOp  in  OPW  ALU opcode
- IssueDest  in  3  ROB tag of this instruction (the ROB tail index)
- IssueRdyA / IssueRdyB  in  1  operand already valid
- IssueValA / IssueValB  in  32  operand value, used when Rdy=1
- IssueTagA / IssueTagB  in  3  producing ROB tag, used when Rdy=0
- CDB  in  148  slot k = CDB[36k+35:36k] (k=0 DP, 1 MEM, 2 MUL, 3 FP); [35:4] value, [3] valid, [2:0] ROB tag; bits 147:144 ignored
- EX_Valid  out  1  a dispatchable entry is presented
- EX_Ready  in  1  ALU accepts this cycle
- EX_Op  out  OPW  opcode of the presented entry
- EX_A / EX_B  out  32  operand values of the presented entry
- EX_Dest  out  3  ROB tag of the presented entry
- Count  out  $clog2(DEPTH+1)  number of busy entries

## Operation
- Per-entry registered state: Busy, Op, Dest, RdyA, RdyB, ValA, ValB, TagA, TagB.
- Issue accept: Issue & ~Full. The entry written is the lowest-index non-busy entry.
  - For each operand: if Rdy=1, store the value and set Rdy.
  - If Rdy=0 and some CDB slot in the same cycle is valid with tag == IssueTag, store that slot's value and set Rdy (same-cycle bypass).
  - Otherwise store the tag and clear Rdy.
- CDB snoop: every busy entry with Rdy=0 on an operand compares its tag against all 4 slots.
  - On a match, it latches the value and sets Rdy at the clock edge.
  - If several slots match, the lowest slot index wins.
  - Both operands of one entry may capture in the same cycle, from the same or different slots.
- Dispatch select: among entries with Busy & RdyA & RdyB, take the lowest index.
  - EX_* are combinational from registered state only; a CDB capture is visible the cycle after it occurs.
  - EX_Valid = 1 when any entry is dispatchable. EX_Op/A/B/Dest are 0 when EX_Valid = 0.
- Dispatch fire: EX_Valid & EX_Ready clears Busy of the selected entry at the edge.
  - EX_* must stay stable while EX_Valid=1 & EX_Ready=0, unless a lower-index entry becomes ready.
  - A switch to a lower-index entry is permitted only because nothing has fired.
- Full = (Count == DEPTH), from registered Busy. A slot freed by dispatch is reusable starting the next cycle; there is no same-cycle free-and-issue.
- Issue and dispatch in the same cycle: both take effect. Count is unchanged.
- Reset: all Busy and Rdy cleared, Count=0, Full=0, EX_Valid=0, EX_* = 0.
  - Asserting Reset mid-operation discards all entries.
  - Value registers need no reset.

## Timing
- Issue with both operands ready at edge N: EX_Valid=1 in cycle N+1, if no lower-index entry is ready.
- CDB broadcast of a missing tag in cycle N: the entry becomes dispatchable in N+1.
- Issue-to-ALU minimum latency: 1 cycle. Throughput: 1 dispatch and 1 issue per cycle.
- Full and Count update one cycle after the causing edge. Both are registered-derived and glitch-free.

## Test plan
- Reset, then issue Op=3, A=5, B=7, Dest=2, both ready:
  - Next cycle: EX_Valid=1, EX_A=5, EX_B=7, EX_Dest=2.
  - With EX_Ready=1: Count returns 0.
- Issue with RdyA=0, TagA=4:
  - EX_Valid stays 0.
  - Drive CDB MUL slot {value=0x1234, valid, tag 4}: next cycle EX_Valid=1, EX_A=0x1234.
- Same-cycle bypass: issue TagB=6 while CDB MEM slot carries tag 6, value 9. Next cycle EX_B=9, EX_Valid=1.
- Fill 4 entries with unready operands:
  - Full=1; a 5th Issue is ignored and Count stays 4.
  - Broadcast tags so that entries 2 and 0 become ready in the same cycle: entry 0 dispatches first, then entry 2.
- Backpressure: hold EX_Ready=0 for 3 cycles with one ready entry. EX_* stay constant and Count does not change.
- Simultaneous issue and dispatch at Full-1:
  - Count stays constant and Full stays 0.
  - Assert Reset mid-stream: EX_Valid=0 and Count=0 immediately (asynchronous).
